// File: rtl/usb_cdc_arb_pkg.sv
// Shared types and default tuning values for the USB CDC IN-stream arbiter.
package usb_cdc_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_MAX_BURST    = 64;
    localparam int ARB_IDLE_TIMEOUT = 1024;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requesting index after last_ptr_i,
// wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_ptr_i,
    output logic [NUM_REQ-1:0] winner_o,
    output logic [IDX_W-1:0]   winner_idx_o,
    output logic               any_o
);

    int cand;

    always_comb begin
        winner_o     = '0;
        winner_idx_o = '0;
        any_o        = 1'b0;
        cand         = 0;
        // Offsets 1..NUM_REQ visit every index once, with last_ptr_i itself last.
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = int'(last_ptr_i) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any_o && req_i[IDX_W'(cand)]) begin
                any_o                   = 1'b1;
                winner_o[IDX_W'(cand)]  = 1'b1;
                winner_idx_o            = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/usb_cdc_tx_arbiter.sv
// Message-granular round-robin arbiter sharing the CDC core's byte-wide IN
// port between on-chip requesters, with a per-grant byte budget and idle timeout.
module usb_cdc_tx_arbiter
    import usb_cdc_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int MAX_BURST    = ARB_MAX_BURST,
    parameter int IDLE_TIMEOUT = ARB_IDLE_TIMEOUT
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ*8-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_accept_o,
    output logic                 inport_valid_o,
    output logic [7:0]           inport_data_o,
    input  logic                 inport_accept_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 busy_o
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int IDLE_W  = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    localparam bit                 TIMEOUT_EN = (IDLE_TIMEOUT > 0);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
    localparam logic [IDLE_W-1:0]  IDLE_SAT   = IDLE_W'(IDLE_TIMEOUT);

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     last_ptr_q, last_ptr_d;
    logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;

    logic [NUM_REQ-1:0]   pick_req;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;

    logic                 owner_valid;
    logic                 owner_last;
    logic [7:0]           owner_data;
    logic                 handshake;
    logic                 release_now;

    assign pick_req = enable_i ? req_valid_i : '0;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i        (pick_req),
        .last_ptr_i   (last_ptr_q),
        .winner_o     (pick_onehot),
        .winner_idx_o (pick_idx),
        .any_o        (pick_any)
    );

    // Pass-through data path from the registered owner; no buffering.
    always_comb begin
        owner_valid    = req_valid_i[owner_q];
        owner_last     = req_last_i[owner_q];
        owner_data     = req_data_i[{owner_q, 3'b000} +: 8];
        inport_valid_o = 1'b0;
        inport_data_o  = 8'h00;
        req_accept_o   = '0;
        handshake      = 1'b0;
        if (state_q == GRANT) begin
            inport_valid_o        = enable_i & owner_valid;
            inport_data_o         = owner_data;
            req_accept_o[owner_q] = enable_i & inport_accept_i & owner_valid;
            handshake             = enable_i & owner_valid & inport_accept_i;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_ptr_d  = last_ptr_q;
        burst_cnt_d = burst_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        grant_d     = grant_q;
        release_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d     = GRANT;
                    owner_d     = pick_idx;
                    last_ptr_d  = pick_idx;
                    burst_cnt_d = '0;
                    idle_cnt_d  = '0;
                    grant_d     = pick_onehot;
                end
            end
            GRANT: begin
                // Any single cause releases; coinciding causes are still one release.
                release_now = !enable_i
                            || (handshake && owner_last)
                            || (handshake && (burst_cnt_q == BURST_LAST))
                            || (TIMEOUT_EN && !owner_valid && (idle_cnt_q == IDLE_LAST));
                if (release_now) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else begin
                    if (handshake) begin
                        burst_cnt_d = burst_cnt_q + BURST_W'(1);
                    end
                    if (owner_valid) begin
                        idle_cnt_d = '0;
                    end else if (TIMEOUT_EN && (idle_cnt_q != IDLE_SAT)) begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // last_ptr resets to the top index so requester 0 wins the first pick.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            last_ptr_q  <= IDX_W'(NUM_REQ - 1);
            burst_cnt_q <= '0;
            idle_cnt_q  <= '0;
            grant_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_ptr_q  <= last_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            grant_q     <= grant_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == GRANT);

endmodule

// File: tb/tb_usb_cdc_tx_arbiter.sv
// Directed bench for usb_cdc_tx_arbiter: two requesters, 4-byte budget,
// 8-cycle idle timeout, byte scoreboard checked on every handshake.
module tb_usb_cdc_tx_arbiter;

    localparam int NUM_REQ = 2;

    logic                 clk = 1'b0;
    logic                 rst_ni;
    logic                 enable_i;
    logic [NUM_REQ-1:0]   req_valid_i;
    logic [NUM_REQ*8-1:0] req_data_i;
    logic [NUM_REQ-1:0]   req_last_i;
    logic [NUM_REQ-1:0]   req_accept_o;
    logic                 inport_valid_o;
    logic [7:0]           inport_data_o;
    logic                 inport_accept_i;
    logic [NUM_REQ-1:0]   grant_o;
    logic                 busy_o;

    logic [8:0] src0_q[$];
    logic [8:0] src1_q[$];
    logic [8:0] exp_q[$];
    logic [1:0] acc_s;
    int         checks = 0;
    int         errors = 0;

    usb_cdc_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .MAX_BURST    (4),
        .IDLE_TIMEOUT (8)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .enable_i        (enable_i),
        .req_valid_i     (req_valid_i),
        .req_data_i      (req_data_i),
        .req_last_i      (req_last_i),
        .req_accept_o    (req_accept_o),
        .inport_valid_o  (inport_valid_o),
        .inport_data_o   (inport_data_o),
        .inport_accept_i (inport_accept_i),
        .grant_o         (grant_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_inputs();
        req_valid_i[0]   = (src0_q.size() != 0);
        req_data_i[7:0]  = (src0_q.size() != 0) ? src0_q[0][7:0] : 8'h00;
        req_last_i[0]    = (src0_q.size() != 0) ? src0_q[0][8] : 1'b0;
        req_valid_i[1]   = (src1_q.size() != 0);
        req_data_i[15:8] = (src1_q.size() != 0) ? src1_q[0][7:0] : 8'h00;
        req_last_i[1]    = (src1_q.size() != 0) ? src1_q[0][8] : 1'b0;
    endtask

    task automatic load_src(input int k, input logic [7:0] base, input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            logic [8:0] w;
            w = {(with_last && (i == n - 1)), base + 8'(i)};
            if (k == 0) src0_q.push_back(w);
            else        src1_q.push_back(w);
        end
        apply_inputs();
    endtask

    task automatic push_exp(input int k, input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'(k), base + 8'(i)});
        end
    endtask

    // One clock: monitor handshakes mid-cycle, then requesters react after the edge.
    task automatic tick();
        logic [8:0] e;
        @(negedge clk);
        acc_s = req_accept_o;
        if (inport_valid_o && inport_accept_i) begin
            if (exp_q.size() == 0) begin
                chk("hs_unexpected", {7'd0, grant_o[1], inport_data_o}, 16'hFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("hs_byte", {7'd0, grant_o[1], inport_data_o}, {7'd0, e});
            end
            chk("hs_accept", {14'd0, req_accept_o}, {14'd0, grant_o});
        end else begin
            chk("no_accept", {14'd0, req_accept_o}, 16'h0000);
        end
        @(posedge clk);
        #1;
        if (acc_s[0] && src0_q.size() != 0) void'(src0_q.pop_front());
        if (acc_s[1] && src1_q.size() != 0) void'(src1_q.pop_front());
        apply_inputs();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            tick();
            n++;
        end
        chk(tag, 16'(exp_q.size()), 16'h0000);
    endtask

    initial begin
        rst_ni          = 1'b0;
        enable_i        = 1'b1;
        inport_accept_i = 1'b1;
        req_valid_i     = '0;
        req_data_i      = '0;
        req_last_i      = '0;

        // Reset: requester 0 already valid, nothing may be granted or accepted.
        load_src(0, 8'h41, 4, 1'b1);
        push_exp(0, 8'h41, 4);
        tick();
        tick();
        chk("rst_grant", 16'(grant_o), 16'h0000);
        chk("rst_busy", 16'(busy_o), 16'h0000);
        chk("rst_valid", 16'(inport_valid_o), 16'h0000);
        chk("rst_accept", 16'(req_accept_o), 16'h0000);
        rst_ni = 1'b1;

        // Single source: 4 bytes, last coincides with the budget end.
        tick();
        chk("t1_grant", 16'(grant_o), 16'h0001);
        chk("t1_busy", 16'(busy_o), 16'h0001);
        chk("t1_data", 16'(inport_data_o), 16'h0041);
        repeat (3) tick();
        chk("t1_hold", 16'(grant_o), 16'h0001);
        tick();
        chk("t1_release", 16'(grant_o), 16'h0000);
        chk("t1_empty", 16'(exp_q.size()), 16'h0000);

        // Round-robin after a fresh reset: grants 0,1,0,1 with one bubble each.
        rst_ni = 1'b0;
        load_src(0, 8'h10, 3, 1'b1);
        load_src(0, 8'h13, 3, 1'b1);
        load_src(1, 8'h20, 3, 1'b1);
        load_src(1, 8'h23, 3, 1'b1);
        push_exp(0, 8'h10, 3);
        push_exp(1, 8'h20, 3);
        push_exp(0, 8'h13, 3);
        push_exp(1, 8'h23, 3);
        tick();
        chk("t2_rst_busy", 16'(busy_o), 16'h0000);
        rst_ni = 1'b1;
        for (int m = 0; m < 4; m++) begin
            tick();
            chk("t2_grant", 16'(grant_o), (m % 2 == 0) ? 16'h0001 : 16'h0002);
            tick();
            tick();
            chk("t2_hold", 16'(grant_o), (m % 2 == 0) ? 16'h0001 : 16'h0002);
            tick();
            chk("t2_bubble", 16'(grant_o), 16'h0000);
        end
        chk("t2_empty", 16'(exp_q.size()), 16'h0000);

        // Burst cap: requester 1 sends 10 bytes, requester 0 cuts in after 4.
        load_src(1, 8'h60, 10, 1'b1);
        push_exp(1, 8'h60, 4);
        push_exp(0, 8'h70, 2);
        push_exp(1, 8'h64, 4);
        push_exp(1, 8'h68, 2);
        tick();
        chk("t3_grant1", 16'(grant_o), 16'h0002);
        load_src(0, 8'h70, 2, 1'b1);
        repeat (3) tick();
        chk("t3_hold", 16'(grant_o), 16'h0002);
        tick();
        chk("t3_cap_release", 16'(grant_o), 16'h0000);
        tick();
        chk("t3_grant0", 16'(grant_o), 16'h0001);
        drain("t3_drain");
        chk("t3_end", 16'(grant_o), 16'h0000);

        // Idle timeout: owner stops after 2 bytes without last.
        load_src(0, 8'h80, 2, 1'b0);
        push_exp(0, 8'h80, 2);
        tick();
        chk("t4_grant", 16'(grant_o), 16'h0001);
        tick();
        tick();
        repeat (7) tick();
        chk("t4_idle_hold", 16'(grant_o), 16'h0001);
        tick();
        chk("t4_timeout", 16'(grant_o), 16'h0000);
        chk("t4_empty", 16'(exp_q.size()), 16'h0000);

        // Backpressure: 20 stalled cycles, no release and no accept.
        inport_accept_i = 1'b0;
        load_src(1, 8'h90, 2, 1'b1);
        push_exp(1, 8'h90, 2);
        tick();
        chk("t4b_grant", 16'(grant_o), 16'h0002);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t4b_stall", 16'(grant_o), 16'h0002);
        end
        chk("t4b_valid", 16'(inport_valid_o), 16'h0001);
        inport_accept_i = 1'b1;
        drain("t4b_drain");
        chk("t4b_end", 16'(grant_o), 16'h0000);

        // Disable after byte 2: same-cycle gating, IDLE after the edge.
        load_src(0, 8'hA0, 5, 1'b1);
        push_exp(0, 8'hA0, 2);
        tick();
        chk("t5_grant", 16'(grant_o), 16'h0001);
        tick();
        tick();
        enable_i = 1'b0;
        #1;
        chk("t5_gate_valid", 16'(inport_valid_o), 16'h0000);
        chk("t5_gate_accept", 16'(req_accept_o), 16'h0000);
        chk("t5_gate_grant", 16'(grant_o), 16'h0001);
        tick();
        chk("t5_idle_grant", 16'(grant_o), 16'h0000);
        chk("t5_idle_busy", 16'(busy_o), 16'h0000);
        enable_i = 1'b1;
        push_exp(0, 8'hA2, 3);
        drain("t5_drain");
        chk("t5_end", 16'(grant_o), 16'h0000);

        // Reset mid-message from requester 1; requester 0 must win afterwards.
        load_src(1, 8'hB0, 4, 1'b1);
        push_exp(1, 8'hB0, 1);
        tick();
        chk("t6_grant", 16'(grant_o), 16'h0002);
        tick();
        rst_ni = 1'b0;
        #1;
        chk("t6_async_grant", 16'(grant_o), 16'h0000);
        chk("t6_async_busy", 16'(busy_o), 16'h0000);
        chk("t6_async_valid", 16'(inport_valid_o), 16'h0000);
        chk("t6_async_accept", 16'(req_accept_o), 16'h0000);
        load_src(0, 8'hC0, 2, 1'b1);
        tick();
        chk("t6_rst_grant", 16'(grant_o), 16'h0000);
        rst_ni = 1'b1;
        push_exp(0, 8'hC0, 2);
        push_exp(1, 8'hB1, 3);
        tick();
        chk("t6_first_after_rst", 16'(grant_o), 16'h0001);
        drain("t6_drain");
        chk("t6_end", 16'(grant_o), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
